// File: rtl/reg_dump_tx.sv
// Walks every architectural register through a read port and streams it out bytewise.
// Optional two-byte header (0xA5, REG_COUNT[7:0]) enabled by defining REG_DUMP_HEADER_EN.
module reg_dump_tx #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_COUNT  = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic [DATA_WIDTH-1:0] rd_data_i,
   output logic [7:0]            tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_ready_i,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   localparam int unsigned CntWidth = (NumBytes > 2) ? $clog2(NumBytes) : 1;
   localparam logic [CntWidth-1:0]   LastByte = CntWidth'(NumBytes - 1);
   localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(REG_COUNT - 1);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StRead = 3'd1;
   localparam logic [2:0] StSend = 3'd2;
   localparam logic [2:0] StDone = 3'd3;
`ifdef REG_DUMP_HEADER_EN
   localparam logic [2:0] StHeader = 3'd4;
   localparam logic [7:0] HdrMagic = 8'hA5;
   localparam logic [7:0] HdrCount = 8'(REG_COUNT);
`endif

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [CntWidth-1:0]   byte_cnt_q, byte_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  xfer;

   assign xfer = tx_valid_o && tx_ready_i;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               idx_d      = '0;
               byte_cnt_d = '0;
`ifdef REG_DUMP_HEADER_EN
               state_d    = StHeader;
`else
               state_d    = StRead;
`endif
            end
         end
`ifdef REG_DUMP_HEADER_EN
         StHeader: begin
            if (xfer) begin
               if (byte_cnt_q != '0) begin
                  byte_cnt_d = '0;
                  state_d    = StRead;
               end else begin
                  byte_cnt_d = byte_cnt_q + CntWidth'(1);
               end
            end
         end
`endif
         StRead: begin
            shift_d    = rd_data_i;
            byte_cnt_d = '0;
            state_d    = StSend;
         end
         StSend: begin
            if (xfer) begin
               shift_d    = shift_q >> 8;
               byte_cnt_d = byte_cnt_q + CntWidth'(1);
               if (byte_cnt_q == LastByte) begin
                  if (idx_q == LastIdx) begin
                     state_d = StDone;
                  end else begin
                     idx_d   = idx_q + ADDR_WIDTH'(1);
                     state_d = StRead;
                  end
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
      end
   end

   // idx only moves on the SEND->READ hop, so it doubles as the held read address.
   assign rd_addr_o = idx_q;
   assign busy_o    = (state_q != StIdle);
   assign done_o    = (state_q == StDone);

   always_comb begin
      tx_valid_o = 1'b0;
      tx_data_o  = 8'h00;
      if (state_q == StSend) begin
         tx_valid_o = 1'b1;
         tx_data_o  = shift_q[7:0];
      end
`ifdef REG_DUMP_HEADER_EN
      if (state_q == StHeader) begin
         tx_valid_o = 1'b1;
         tx_data_o  = (byte_cnt_q == '0) ? HdrMagic : HdrCount;
      end
`endif
   end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: scenario table, spot-byte table, and reset/backpressure sequences.
module tb_reg_dump_tx;

   localparam int DW = 32;
   localparam int RC = 32;
   localparam int AW = 5;
   localparam int NB = DW / 8;
`ifdef REG_DUMP_HEADER_EN
   localparam int Hdr = 2;
`else
   localparam int Hdr = 0;
`endif

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          busy;
   logic          done;

   logic [DW-1:0] regs [RC];
   assign rd_data = regs[rd_addr];

   reg_dump_tx #(
      .DATA_WIDTH(DW),
      .REG_COUNT (RC),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (start),
      .rd_addr_o (rd_addr),
      .rd_data_i (rd_data),
      .tx_data_o (tx_data),
      .tx_valid_o(tx_valid),
      .tx_ready_i(tx_ready),
      .busy_o    (busy),
      .done_o    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] cap [$];
   int done_cyc;
   int done_cnt;
   int idle_bad;

   typedef struct {
      int pat;
      int stall_at;
      int stall_len;
      int extra_start;
      int exp_len;
      int exp_done;
   } scen_t;

   typedef struct {
      int         pat;
      int         pos;
      logic [7:0] exp;
   } spot_t;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fill(input int pat);
      for (int i = 0; i < RC; i++) begin
         if (pat == 0) regs[i] = (i == 2) ? 32'h0000_0FF0 : 32'h0;
         else          regs[i] = 32'h1122_3300 + 32'(i);
      end
   endtask

   // Called at a negedge. Cycle 1 is the cycle in which start is presented.
   task automatic run_dump(input int stall_at, input int stall_len, input int extra);
      int stall_rem;
      logic [7:0] held;
      cap.delete();
      done_cyc  = -1;
      done_cnt  = 0;
      idle_bad  = 0;
      stall_rem = stall_len;
      held      = 8'h00;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         tx_ready = 1'b1;
         if (tx_valid && stall_rem > 0 && (cap.size() - Hdr) == stall_at) begin
            tx_ready = 1'b0;
            if (stall_rem == stall_len) held = tx_data;
            else check("stall_hold_data", tx_data, held);
            stall_rem--;
         end
         if (tx_valid && tx_ready) cap.push_back(tx_data);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (done_cyc > 0 && cyc > done_cyc && (busy || tx_valid)) idle_bad = 1;
         start = (cyc == 1) || ((extra != 0) && (cyc == 10 || done));
         @(negedge clk);
         if (done_cyc > 0 && cyc >= done_cyc + 6) break;
      end
      start    = 1'b0;
      tx_ready = 1'b1;
      if (done_cyc < 0) check("done_timeout", 0, 1);
   endtask

   scen_t sc [4];
   spot_t sp [12];

   initial begin
      int errs;
      int waited;
      logic [7:0] e;

      sc[0] = '{pat: 0, stall_at: -1, stall_len: 0, extra_start: 0, exp_len: 128, exp_done: 162};
      sc[1] = '{pat: 1, stall_at: -1, stall_len: 0, extra_start: 0, exp_len: 128, exp_done: 162};
      sc[2] = '{pat: 1, stall_at: 6,  stall_len: 3, extra_start: 0, exp_len: 128, exp_done: 165};
      sc[3] = '{pat: 1, stall_at: -1, stall_len: 0, extra_start: 1, exp_len: 128, exp_done: 162};

      sp[0]  = '{pat: 0, pos: 8,   exp: 8'hF0};
      sp[1]  = '{pat: 0, pos: 9,   exp: 8'h0F};
      sp[2]  = '{pat: 0, pos: 10,  exp: 8'h00};
      sp[3]  = '{pat: 0, pos: 11,  exp: 8'h00};
      sp[4]  = '{pat: 0, pos: 0,   exp: 8'h00};
      sp[5]  = '{pat: 0, pos: 127, exp: 8'h00};
      sp[6]  = '{pat: 1, pos: 20,  exp: 8'h05};
      sp[7]  = '{pat: 1, pos: 21,  exp: 8'h33};
      sp[8]  = '{pat: 1, pos: 22,  exp: 8'h22};
      sp[9]  = '{pat: 1, pos: 23,  exp: 8'h11};
      sp[10] = '{pat: 1, pos: 6,   exp: 8'h22};
      sp[11] = '{pat: 1, pos: 124, exp: 8'h1F};

      rst_n    = 1'b0;
      start    = 1'b0;
      tx_ready = 1'b1;
      fill(0);
      repeat (2) @(negedge clk);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int s = 0; s < 4; s++) begin
         fill(sc[s].pat);
         run_dump(sc[s].stall_at, sc[s].stall_len, sc[s].extra_start);
         check($sformatf("s%0d_len", s), cap.size(), sc[s].exp_len + Hdr);
         check($sformatf("s%0d_done_cycle", s), done_cyc, sc[s].exp_done + Hdr);
         check($sformatf("s%0d_done_count", s), done_cnt, 1);
         check($sformatf("s%0d_idle_after", s), idle_bad, 0);
`ifdef REG_DUMP_HEADER_EN
         check($sformatf("s%0d_hdr0", s), cap[0], 8'hA5);
         check($sformatf("s%0d_hdr1", s), cap[1], 8'h20);
`endif
         errs = 0;
         for (int p = 0; p < RC * NB; p++) begin
            e = 8'(regs[p / NB] >> (8 * (p % NB)));
            if (p + Hdr >= cap.size() || cap[p + Hdr] != e) errs++;
         end
         check($sformatf("s%0d_stream_errs", s), errs, 0);
         for (int v = 0; v < 12; v++) begin
            if (sp[v].pat == sc[s].pat) begin
               if (sp[v].pos + Hdr < cap.size())
                  check($sformatf("s%0d_byte%0d", s, sp[v].pos), cap[sp[v].pos + Hdr], sp[v].exp);
               else
                  check($sformatf("s%0d_byte%0d_missing", s, sp[v].pos), 0, 1);
            end
         end
      end

      // Reset while register 10 is being sent, with a byte held pending.
      fill(1);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      waited = 0;
      while (!(tx_valid && rd_addr == 5'd10) && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      check("mid_reached_idx10", waited < 300, 1);
      tx_ready = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      tx_ready = 1'b1;
      check("mid_rst_rd_addr", rd_addr, 0);
      check("mid_rst_tx_data", tx_data, 0);
      check("mid_rst_tx_valid", tx_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      errs = 0;
      for (int c = 0; c < 20; c++) begin
         if (done || busy || tx_valid) errs++;
         @(negedge clk);
      end
      check("mid_rst_stays_idle", errs, 0);

      run_dump(-1, 0, 0);
      check("restart_len", cap.size(), 128 + Hdr);
      check("restart_b0", cap[Hdr + 0], 8'h00);
      check("restart_b1", cap[Hdr + 1], 8'h33);
      check("restart_b2", cap[Hdr + 2], 8'h22);
      check("restart_b3", cap[Hdr + 3], 8'h11);
      check("restart_done_count", done_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_dump_tx.md
Name: reg_dump_tx

Overview:
- Read-side companion to the register file: walks all architectural registers through a read port after program completion.
- Serialises each register onto a byte-wide valid/ready stream, typically feeding the SoC UART TX path.
- Replaces simulation-only file dumps with a synthesizable readout of the final register state.
- Sits beside the decode-stage register file and is triggered by the processor's process_done pulse.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- REG_COUNT, 32, number of registers dumped (indices 0..REG_COUNT-1).
- ADDR_WIDTH, 5, width of the register index; must satisfy 2**ADDR_WIDTH >= REG_COUNT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstN  input  1  synchronous active-low reset.
- start  input  1  dump request (process_done); sampled only in IDLE.
- rd_addr  output  ADDR_WIDTH  register index driven to the register file read port.
- rd_data  input  DATA_WIDTH  combinational read data for rd_addr, valid in the same cycle.
- tx_data  output  8  stream byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte.
- busy  output  1  high from the cycle after start is accepted until DONE is exited.
- done  output  1  single-cycle pulse when the dump completes.

Behaviour:
- Reset: synchronous, active-low; rstN==0 at a rising edge has priority over all other inputs. It forces:
  - state=IDLE, idx=0, byte_cnt=0, shift register=0;
  - rd_addr=0, tx_data=0, tx_valid=0, busy=0, done=0.
- Reset mid-dump: the dump aborts at that edge with no partial completion and no done pulse. tx_valid drops even if a byte is pending.
- FSM states: IDLE, READ, SEND, DONE.
  - IDLE: start==1 -> READ, idx=0. start==0 -> stay.
  - READ: rd_addr=idx. At the edge, capture rd_data into the shift register, set byte_cnt=0, go to SEND.
  - SEND: tx_valid=1 and tx_data=shift[7:0]. A transfer occurs at an edge where tx_valid && tx_ready.
    - On transfer: shift right by 8 and increment byte_cnt.
    - After the last byte (byte_cnt==DATA_WIDTH/8-1): if idx==REG_COUNT-1 go to DONE, else increment idx and go to READ.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Byte order: little-endian per register, registers in ascending index order.
- Total stream length: REG_COUNT*DATA_WIDTH/8 bytes (128 at defaults).
- Stream rules:
  - tx_data is stable and tx_valid stays high while tx_valid && !tx_ready.
  - tx_valid never depends combinationally on tx_ready.
  - tx_valid is low in IDLE, READ and DONE, so there is one bubble cycle between registers.
- Latency: with tx_ready tied high, tx_valid first rises two rising edges after the edge that samples start.
  - Dump duration: REG_COUNT*(1+DATA_WIDTH/8)+2 cycles from start to done.
- start while busy (READ/SEND/DONE) is ignored, with no queuing. start high in the same cycle as DONE is also ignored.
- Snapshot semantics:
  - Each register is sampled in its own READ cycle. Writes to a register after its READ are not reflected in the stream.
  - There is no global atomicity; the processor is expected to be halted.
- idx never exceeds REG_COUNT-1 and does not wrap.
- rd_addr holds its last value outside READ.

Optional Feature:
- Macro: REG_DUMP_HEADER_EN.
- Defined:
  - After start is accepted, two header bytes precede register data: 0xA5, then REG_COUNT[7:0].
  - They are sent in an extra HEADER state with the same valid/ready rules.
  - Header sequence is IDLE -> HEADER (2 bytes) -> READ.
  - Stream length is +2 bytes, dump duration is +2 cycles, and first tx_valid latency is one edge.
- Undefined: no HEADER state; the stream begins with byte 0 of register 0.

Test Plan:
- Basic dump:
  - Stimulus: regfile after reset (x2=0x00000FF0, others 0), tx_ready=1, start pulse.
  - Response: 128 bytes; bytes 8..11 = F0 0F 00 00, all others 00; done pulses once at cycle 162 after start; busy low after.
- Pattern:
  - Stimulus: x[i]=0x11223300+i.
  - Response: register 5 yields 05 33 22 11 at stream bytes 20..23.
- Backpressure:
  - Stimulus: tx_ready low for 3 cycles while byte 6 is presented.
  - Response: tx_data stays constant (byte 2 of x1) with tx_valid=1; no byte lost or duplicated; total still 128.
- Start while busy:
  - Stimulus: extra start pulses during SEND and in the DONE cycle.
  - Response: exactly one dump and one done pulse.
- Reset mid-dump:
  - Stimulus: rstN=0 for 1 cycle while at idx=10.
  - Response: next cycle all outputs 0, state IDLE, no done. A following start restarts from register 0.
- Header (REG_DUMP_HEADER_EN):
  - Stimulus: start.
  - Response: first bytes A5 20, then register 0 data; 130 bytes total.
